psum_accumulator: RTL and testbench

Accumulates the 16-lane × 24-bit partial-sum rows produced by the systolic array across a programmable number of K-passes, holding one 16×16 output tile in a register buffer. Once the final pass has been accumulated, it streams the tile to `ppu` as 16 back-to-back rows on `partial_sum`/`valid`. The block sits directly upstream of `ppu` and downstream of the PE array's column outputs.

---
 rtl/psum_accumulator_if.sv | 30 +++
 rtl/psum_accumulator.sv | 182 ++++++++++++++++++
 tb/tb_psum_accumulator.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/psum_accumulator_if.sv
// Row-stream bundle between the upstream PE column outputs, psum_accumulator and ppu.
// Input side: in_valid/in_ready/in_data carry one 16-lane psum row per accepted beat.
// Output side: partial_sum/valid carry drained tile rows (no ready; the consumer must always accept).
// master = the side that feeds rows in and observes the drained rows; slave = the accumulator.
interface psum_accumulator_if #(
    parameter int LANES  = 16,
    parameter int PSUM_W = 24
);
    logic                      in_valid;
    logic                      in_ready;
    logic [LANES*PSUM_W-1:0]   in_data;
    logic [LANES*PSUM_W-1:0]   partial_sum;
    logic                      valid;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  partial_sum,
        input  valid
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output partial_sum,
        output valid
    );
endinterface

// File: rtl/psum_accumulator.sv
// Purpose: accumulate 16-lane x 24-bit psum rows over N K-passes into one 16x16 tile, then drain it to ppu.
// Latency: last beat accepted at edge T -> rows 0..15 on partial_sum/valid in cycles T+1..T+16, done at T+17.
// Backpressure: in_ready high only in ACCUM (gaps stall counters); drain has none, rows go out back-to-back.
// Ports: clk, rst_n (async, active-low); start + num_passes begin a job (IDLE only); bus (slave modport)
//        carries in_valid/in_ready/in_data and partial_sum/valid; done pulse, busy level, sticky sat_flag.
// Option macro PSUM_ACC_SAT_EN: saturating signed accumulation with sat_flag; undefined = wrap mod 2^24, sat_flag=0.
module psum_accumulator #(
    parameter int LANES  = 16,
    parameter int ROWS   = 16,
    parameter int PSUM_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        num_passes,
    psum_accumulator_if.slave bus,
    output logic              done,
    output logic              busy,
    output logic              sat_flag
);
    localparam int                ROW_W    = $clog2(ROWS);
    localparam int                ROW_BITS = LANES * PSUM_W;
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;

    logic [ROW_BITS-1:0]  tile_buf [ROWS];
    logic [ROW_BITS-1:0]  sum_row;
    logic [ROW_W-1:0]     row_cnt;
    logic [ROW_W-1:0]     drain_row;
    logic [3:0]           pass_cnt;
    logic [3:0]           passes;
    logic                 done_q;

    logic                 job_start;
    logic                 accept;
    logic                 last_beat;
    logic                 drain_last;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        job_start  = 1'b0;
        accept     = 1'b0;
        last_beat  = 1'b0;
        drain_last = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    job_start = 1'b1;
                    state_d   = ACCUM;
                end
            end
            ACCUM: begin
                accept = bus.in_valid;
                // passes is never 0, so passes-1 cannot underflow
                if (bus.in_valid && (row_cnt == ROW_LAST) && (pass_cnt == passes - 4'd1)) begin
                    last_beat = 1'b1;
                    state_d   = DRAIN;
                end
            end
            DRAIN: begin
                drain_last = (drain_row == ROW_LAST);
                if (drain_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Counters and job parameters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt   <= '0;
            pass_cnt  <= '0;
            passes    <= 4'd1;
            drain_row <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= drain_last;
            if (job_start) begin
                row_cnt  <= '0;
                pass_cnt <= '0;
                passes   <= (num_passes == 4'd0) ? 4'd1 : num_passes;
            end else if (accept) begin
                row_cnt <= row_cnt + 1'b1;
                if (row_cnt == ROW_LAST) begin
                    pass_cnt <= pass_cnt + 4'd1;
                end
            end
            // drain_row parks on the last row after DRAIN so partial_sum keeps showing it
            if (last_beat) begin
                drain_row <= '0;
            end else if ((state_q == DRAIN) && !drain_last) begin
                drain_row <= drain_row + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-lane accumulate
    // ------------------------------------------------------------------
`ifdef PSUM_ACC_SAT_EN
    localparam logic [PSUM_W-1:0] SAT_MAX = {1'b0, {(PSUM_W-1){1'b1}}};
    localparam logic [PSUM_W-1:0] SAT_MIN = {1'b1, {(PSUM_W-1){1'b0}}};
    logic [LANES-1:0] lane_clamp;
`endif

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic [PSUM_W-1:0] acc_old;
        logic [PSUM_W-1:0] acc_in;
        assign acc_old = tile_buf[row_cnt][j*PSUM_W +: PSUM_W];
        assign acc_in  = bus.in_data[j*PSUM_W +: PSUM_W];
`ifdef PSUM_ACC_SAT_EN
        // one guard bit: top two bits disagree exactly when the signed sum overflowed
        logic [PSUM_W:0] wide;
        assign wide          = {acc_old[PSUM_W-1], acc_old} + {acc_in[PSUM_W-1], acc_in};
        assign lane_clamp[j] = wide[PSUM_W] ^ wide[PSUM_W-1];
        assign sum_row[j*PSUM_W +: PSUM_W] = lane_clamp[j] ? (wide[PSUM_W] ? SAT_MIN : SAT_MAX)
                                                           : wide[PSUM_W-1:0];
`else
        assign sum_row[j*PSUM_W +: PSUM_W] = acc_old + acc_in;
`endif
    end

    // First pass overwrites, so stale data from an earlier job never leaks in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) begin
                tile_buf[r] <= '0;
            end
        end else if (accept) begin
            tile_buf[row_cnt] <= (pass_cnt == 4'd0) ? bus.in_data : sum_row;
        end
    end

`ifdef PSUM_ACC_SAT_EN
    logic sat_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else if (job_start) begin
            sat_q <= 1'b0;
        end else if (accept && (pass_cnt != 4'd0) && (|lane_clamp)) begin
            sat_q <= 1'b1;
        end
    end
    assign sat_flag = sat_q;
`else
    assign sat_flag = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready    = (state_q == ACCUM);
    assign bus.valid       = (state_q == DRAIN);
    assign bus.partial_sum = tile_buf[drain_row];
    assign busy            = (state_q != IDLE);
    assign done            = done_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed testbench for psum_accumulator: per-scenario tasks with inline checks against hand-computed rows.
module tb_psum_accumulator;
    localparam int LANES  = 16;
    localparam int ROWS   = 16;
    localparam int PSUM_W = 24;
    localparam int W      = LANES * PSUM_W;
`ifdef PSUM_ACC_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] num_passes;
    logic       done;
    logic       busy;
    logic       sat_flag;

    int checks;
    int errors;

    logic [W-1:0] exp_row [ROWS];
    logic [W-1:0] got_row [ROWS];
    logic         got_vld [ROWS];
    logic d_done17, d_busy17, d_vld17, d_done18, d_busy18, d_rdy18;

    psum_accumulator_if #(.LANES(LANES), .PSUM_W(PSUM_W)) bus ();

    psum_accumulator #(.LANES(LANES), .ROWS(ROWS), .PSUM_W(PSUM_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_passes (num_passes),
        .bus        (bus),
        .done       (done),
        .busy       (busy),
        .sat_flag   (sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] mk_row(input int r);
        logic [W-1:0] v;
        v = '0;
        for (int j = 0; j < LANES; j++) v[j*PSUM_W +: PSUM_W] = PSUM_W'(r * 16 + j);
        return v;
    endfunction

    function automatic logic [W-1:0] fill(input logic [PSUM_W-1:0] x);
        logic [W-1:0] v;
        v = '0;
        for (int j = 0; j < LANES; j++) v[j*PSUM_W +: PSUM_W] = x;
        return v;
    endfunction

    function automatic logic [W-1:0] one_lane(input int j, input logic [PSUM_W-1:0] x);
        logic [W-1:0] v;
        v = '0;
        v[j*PSUM_W +: PSUM_W] = x;
        return v;
    endfunction

    // All driving and sampling happens at the falling edge.
    task automatic start_job(input logic [3:0] np);
        start      = 1'b1;
        num_passes = np;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic send_row(input logic [W-1:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Records 16 drain cycles starting one cycle after the last beat, then cycles T+17 and T+18.
    task automatic capture_drain(input bit poke_start, input bit chain_start, input logic [3:0] chain_np);
        for (int r = 0; r < ROWS; r++) begin
            got_row[r] = bus.partial_sum;
            got_vld[r] = bus.valid;
            start      = poke_start && (r == 5);
            num_passes = 4'd2;
            @(negedge clk);
        end
        start    = 1'b0;
        d_done17 = done;
        d_busy17 = busy;
        d_vld17  = bus.valid;
        if (chain_start) begin
            start      = 1'b1;
            num_passes = chain_np;
        end
        @(negedge clk);
        start    = 1'b0;
        d_done18 = done;
        d_busy18 = busy;
        d_rdy18  = bus.in_ready;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; num_passes = 4'd0;
        bus.in_valid = 1'b0; bus.in_data = '0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
        checks++; if (bus.partial_sum !== '0) begin errors++; $display("FAIL reset_partial_sum got %h want 0", bus.partial_sum); end
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.valid); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat_flag got %b want 0", sat_flag); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_pass();
        start_job(4'd1);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL start_in_ready got %b want 1", bus.in_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy got %b want 1", busy); end
        for (int r = 0; r < ROWS; r++) begin
            exp_row[r] = mk_row(r);
            send_row(mk_row(r));
        end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL drain_in_ready got %b want 0", bus.in_ready); end
        capture_drain(1'b0, 1'b0, 4'd0);
        for (int r = 0; r < ROWS; r++) begin
            checks++; if (got_vld[r] !== 1'b1) begin errors++; $display("FAIL single_valid row %0d got %b want 1", r, got_vld[r]); end
            checks++; if (got_row[r] !== exp_row[r]) begin errors++; $display("FAIL single_row %0d got %h want %h", r, got_row[r], exp_row[r]); end
        end
        checks++; if (d_done17 !== 1'b1) begin errors++; $display("FAIL single_done_t17 got %b want 1", d_done17); end
        checks++; if (d_busy17 !== 1'b0) begin errors++; $display("FAIL single_busy_t17 got %b want 0", d_busy17); end
        checks++; if (d_vld17 !== 1'b0) begin errors++; $display("FAIL single_valid_t17 got %b want 0", d_vld17); end
        checks++; if (d_done18 !== 1'b0) begin errors++; $display("FAIL single_done_t18 got %b want 0", d_done18); end
        checks++; if (bus.partial_sum !== mk_row(15)) begin errors++; $display("FAIL single_hold_row15 got %h want %h", bus.partial_sum, mk_row(15)); end
    endtask

    task automatic test_multi_pass();
        start_job(4'd3);
        for (int p = 0; p < 3; p++)
            for (int r = 0; r < ROWS; r++) send_row(fill(24'd5));
        capture_drain(1'b0, 1'b0, 4'd0);
        for (int r = 0; r < ROWS; r++) begin
            checks++; if (got_vld[r] !== 1'b1 || got_row[r] !== fill(24'd15)) begin
                errors++; $display("FAIL multi_row %0d got vld %b %h want vld 1 %h", r, got_vld[r], got_row[r], fill(24'd15));
            end
        end
        checks++; if (d_done17 !== 1'b1) begin errors++; $display("FAIL multi_done got %b want 1", d_done17); end
    endtask

    task automatic test_signed();
        start_job(4'd2);
        for (int r = 0; r < ROWS; r++) send_row(one_lane(0, 24'hFFFFF9));
        for (int r = 0; r < ROWS; r++) send_row(one_lane(0, 24'h000003));
        capture_drain(1'b0, 1'b0, 4'd0);
        for (int r = 0; r < ROWS; r++) begin
            checks++; if (got_vld[r] !== 1'b1 || got_row[r] !== one_lane(0, 24'hFFFFFC)) begin
                errors++; $display("FAIL signed_row %0d got vld %b %h want vld 1 %h", r, got_vld[r], got_row[r], one_lane(0, 24'hFFFFFC));
            end
        end
    endtask

    task automatic test_overflow();
        logic [PSUM_W-1:0] want;
        want = SAT_EN ? 24'h7FFFFF : 24'hFFFFFE;
        start_job(4'd2);
        for (int r = 0; r < ROWS; r++) send_row(one_lane(3, 24'h7FFFFF));
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL ovf_sat_after_pass0 got %b want 0", sat_flag); end
        for (int r = 0; r < ROWS; r++) send_row(one_lane(3, 24'h7FFFFF));
        capture_drain(1'b0, 1'b0, 4'd0);
        for (int r = 0; r < ROWS; r++) begin
            checks++; if (got_row[r] !== one_lane(3, want)) begin
                errors++; $display("FAIL ovf_row %0d got %h want %h", r, got_row[r], one_lane(3, want));
            end
        end
        checks++; if (sat_flag !== SAT_EN) begin errors++; $display("FAIL ovf_sat_flag got %b want %b", sat_flag, SAT_EN); end
    endtask

    task automatic test_stall();
        start_job(4'd1);
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL stall_sat_cleared got %b want 0", sat_flag); end
        for (int r = 0; r < 8; r++) send_row(mk_row(r + 3));
        for (int g = 0; g < 3; g++) begin
            checks++; if (bus.in_ready !== 1'b1 || bus.valid !== 1'b0) begin
                errors++; $display("FAIL stall_gap cycle %0d got rdy %b vld %b want rdy 1 vld 0", g, bus.in_ready, bus.valid);
            end
            @(negedge clk);
        end
        for (int r = 8; r < ROWS; r++) send_row(mk_row(r + 3));
        capture_drain(1'b0, 1'b0, 4'd0);
        for (int r = 0; r < ROWS; r++) begin
            checks++; if (got_vld[r] !== 1'b1 || got_row[r] !== mk_row(r + 3)) begin
                errors++; $display("FAIL stall_row %0d got vld %b %h want vld 1 %h", r, got_vld[r], got_row[r], mk_row(r + 3));
            end
        end
    endtask

    task automatic test_start_during_drain();
        start_job(4'd1);
        for (int r = 0; r < ROWS; r++) send_row(fill(PSUM_W'(r + 7)));
        capture_drain(1'b1, 1'b0, 4'd0);
        for (int r = 0; r < ROWS; r++) begin
            checks++; if (got_vld[r] !== 1'b1 || got_row[r] !== fill(PSUM_W'(r + 7))) begin
                errors++; $display("FAIL poke_row %0d got vld %b %h want vld 1 %h", r, got_vld[r], got_row[r], fill(PSUM_W'(r + 7)));
            end
        end
        checks++; if (d_done17 !== 1'b1) begin errors++; $display("FAIL poke_done got %b want 1", d_done17); end
        checks++; if (d_busy18 !== 1'b0 || d_rdy18 !== 1'b0) begin
            errors++; $display("FAIL poke_idle_after got busy %b rdy %b want busy 0 rdy 0", d_busy18, d_rdy18);
        end
    endtask

    task automatic test_zero_passes();
        start_job(4'd0);
        for (int r = 0; r < ROWS; r++) send_row(mk_row(r + 40));
        capture_drain(1'b0, 1'b0, 4'd0);
        for (int r = 0; r < ROWS; r++) begin
            checks++; if (got_vld[r] !== 1'b1 || got_row[r] !== mk_row(r + 40)) begin
                errors++; $display("FAIL zero_row %0d got vld %b %h want vld 1 %h", r, got_vld[r], got_row[r], mk_row(r + 40));
            end
        end
        checks++; if (d_done17 !== 1'b1) begin errors++; $display("FAIL zero_done got %b want 1", d_done17); end
    endtask

    task automatic test_reset_mid_job();
        int vcount;
        start_job(4'd1);
        for (int r = 0; r < 9; r++) send_row(fill(24'h123456));
        bus.in_valid = 1'b1;
        bus.in_data  = fill(24'hABCDEF);
        rst_n        = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b0 || busy !== 1'b0 || bus.valid !== 1'b0 || done !== 1'b0 || sat_flag !== 1'b0) begin
            errors++; $display("FAIL midrst_ctrl got rdy %b busy %b vld %b done %b sat %b want all 0", bus.in_ready, busy, bus.valid, done, sat_flag);
        end
        checks++; if (bus.partial_sum !== '0) begin errors++; $display("FAIL midrst_partial_sum got %h want 0", bus.partial_sum); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        vcount = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.valid !== 1'b0 || busy !== 1'b0) vcount++;
            @(negedge clk);
        end
        checks++; if (vcount !== 0) begin errors++; $display("FAIL midrst_no_resume got %0d active cycles want 0", vcount); end
        start_job(4'd1);
        for (int r = 0; r < ROWS; r++) send_row(mk_row(r + 20));
        capture_drain(1'b0, 1'b0, 4'd0);
        for (int r = 0; r < ROWS; r++) begin
            checks++; if (got_vld[r] !== 1'b1 || got_row[r] !== mk_row(r + 20)) begin
                errors++; $display("FAIL midrst_row %0d got vld %b %h want vld 1 %h", r, got_vld[r], got_row[r], mk_row(r + 20));
            end
        end
    endtask

    task automatic test_back_to_back();
        start_job(4'd1);
        for (int r = 0; r < ROWS; r++) send_row(fill(24'd1));
        capture_drain(1'b0, 1'b1, 4'd2);
        checks++; if (d_done17 !== 1'b1) begin errors++; $display("FAIL b2b_done got %b want 1", d_done17); end
        checks++; if (d_busy18 !== 1'b1 || d_rdy18 !== 1'b1) begin
            errors++; $display("FAIL b2b_restart got busy %b rdy %b want busy 1 rdy 1", d_busy18, d_rdy18);
        end
        for (int p = 0; p < 2; p++)
            for (int r = 0; r < ROWS; r++) send_row(fill(PSUM_W'(4 + r)));
        capture_drain(1'b0, 1'b0, 4'd0);
        for (int r = 0; r < ROWS; r++) begin
            checks++; if (got_vld[r] !== 1'b1 || got_row[r] !== fill(PSUM_W'(8 + 2 * r))) begin
                errors++; $display("FAIL b2b_row %0d got vld %b %h want vld 1 %h", r, got_vld[r], got_row[r], fill(PSUM_W'(8 + 2 * r)));
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_pass();
        test_multi_pass();
        test_signed();
        test_overflow();
        test_stall();
        test_start_during_drain();
        test_zero_passes();
        test_reset_mid_job();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
